// File: rtl/boolean_link_pkg.sv
// Shared types and helpers for the boolean link tester.
// Holds the sweep FSM states, the reference model and the error saturation value.
package boolean_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  localparam logic [7:0] ERR_SAT = 8'hFF;

  // Reference result of the boolean datapath under test.
  function automatic logic [7:0] bool_expected(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return (a & b) | (~a & b);
  endfunction

endpackage

// File: rtl/boolean_link_tester_err_accum.sv
// Mismatch accumulator: saturating error count and first-failure capture.
// Ports: clk, rst (sync high), clear, mismatch, vec -> err_count, first_fail, failed_flag.
module err_accum
  import boolean_link_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        mismatch,
  input  logic [15:0] vec,
  output logic [7:0]  err_count,
  output logic [15:0] first_fail,
  output logic        failed_flag
);

  logic [7:0]  err_q, err_d;
  logic [15:0] ff_q, ff_d;
  logic        flag_q, flag_d;

  always_comb begin
    err_d  = err_q;
    ff_d   = ff_q;
    flag_d = flag_q;
    if (clear) begin
      err_d  = 8'h00;
      ff_d   = 16'h0000;
      flag_d = 1'b0;
    end else if (mismatch) begin
      if (err_q != ERR_SAT) begin
        err_d = err_q + 8'd1;
      end
      if (!flag_q) begin
        ff_d   = vec;
        flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 8'h00;
      ff_q   <= 16'h0000;
      flag_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      ff_q   <= ff_d;
      flag_q <= flag_d;
    end
  end

  assign err_count   = err_q;
  assign first_fail  = ff_q;
  assign failed_flag = flag_q;

endmodule

// File: rtl/boolean_link_tester.sv
// Sweeps {B,A} vectors into the boolean datapath and checks its result.
// Ports: clk, rst, start, res_in -> a_out, b_out, b_oe, busy, done, pass, err_count, first_fail.
module boolean_link_tester
  import boolean_link_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] LAST_IDX      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  a_out,
  output logic [7:0]  b_out,
  output logic [7:0]  b_oe,
  input  logic [7:0]  res_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [15:0] first_fail
);

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        clear;
  logic        mismatch;
  logic        failed_flag;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    clear    = 1'b0;
    mismatch = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 16'h0000;
          clear   = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          oe_d    = 8'hFF;
          busy_d  = 1'b1;
        end
      end
      DRIVE: begin
        a_d     = idx_q[7:0];
        b_d     = idx_q[15:8];
        cnt_d   = 4'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CHECK: begin
        mismatch = (res_in != bool_expected(a_q, b_q));
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          oe_d    = 8'h00;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Include this cycle's result: the accumulator updates on the same edge.
          pass_d  = (err_count == 8'h00) && !mismatch;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 16'h0000;
      cnt_q   <= 4'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      oe_q    <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  err_accum u_err (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .mismatch    (mismatch),
    .vec         ({b_q, a_q}),
    .err_count   (err_count),
    .first_fail  (first_fail),
    .failed_flag (failed_flag)
  );

  assign a_out = a_q;
  assign b_out = b_q;
  assign b_oe  = oe_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign pass  = pass_q;

endmodule

// File: tb/tb_boolean_link_tester.sv
// Self-checking bench for boolean_link_tester.
// Three instances cover short sweep, saturating sweep and settle-latency cases.
module tb_boolean_link_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [2:0]  start;
  logic [7:0]  a_out [3];
  logic [7:0]  b_out [3];
  logic [7:0]  b_oe [3];
  logic [7:0]  res_in [3];
  logic [7:0]  err_count [3];
  logic [15:0] first_fail [3];
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [2:0]  pass;
  logic        force0;
  logic        dsel;
  logic [7:0]  d1, d2;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int          cyc;
    logic [7:0]  err;
    logic [15:0] ff;
    logic        ps;
  } res_t;

  logic [15:0] vq[$];
  res_t        rq[$];

  // Result sources: ideal model (B), bit-0 stuck low, 1/2-cycle delayed.
  assign res_in[0] = force0 ? {b_out[0][7:1], 1'b0} : b_out[0];
  assign res_in[1] = {b_out[1][7:1], 1'b0};
  assign res_in[2] = dsel ? d2 : d1;

  always @(posedge clk) begin
    d1 <= b_out[2];
    d2 <= d1;
  end

  boolean_link_tester #(.SETTLE_CYCLES(2), .LAST_IDX(16'h000F)) u_a (
    .clk(clk), .rst(rst[0]), .start(start[0]),
    .a_out(a_out[0]), .b_out(b_out[0]), .b_oe(b_oe[0]),
    .res_in(res_in[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err_count[0]),
    .first_fail(first_fail[0])
  );

  boolean_link_tester #(.SETTLE_CYCLES(2), .LAST_IDX(16'h01FF)) u_b (
    .clk(clk), .rst(rst[1]), .start(start[1]),
    .a_out(a_out[1]), .b_out(b_out[1]), .b_oe(b_oe[1]),
    .res_in(res_in[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err_count[1]),
    .first_fail(first_fail[1])
  );

  boolean_link_tester #(.SETTLE_CYCLES(1), .LAST_IDX(16'h01FF)) u_c (
    .clk(clk), .rst(rst[2]), .start(start[2]),
    .a_out(a_out[2]), .b_out(b_out[2]), .b_oe(b_oe[2]),
    .res_in(res_in[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .err_count(err_count[2]),
    .first_fail(first_fail[2])
  );

  // Runs one sweep on unit u; kick>0 re-pulses start at that edge.
  task automatic run_sweep(input int u, input int last,
                           input int per, input int kick);
    int   cyc;
    int   oe_bad;
    res_t r;
    logic [15:0] ev;
    vq.delete();
    for (int i = 0; i <= last; i++) vq.push_back(16'(i));
    oe_bad = 0;
    start[u] = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1 start[u] = 1'b0;
    while (done[u] !== 1'b1 && cyc < (last + 1) * per + 20) begin
      if (cyc >= 2 && ((cyc - 2) % per) == 0 && vq.size() > 0) begin
        ev = vq.pop_front();
        checks++;
        if ({b_out[u], a_out[u]} !== ev)
          $display("FAIL vec u%0d: got %h want %h", u, {b_out[u], a_out[u]}, ev);
        else passed++;
      end
      if (busy[u] !== 1'b1 || b_oe[u] !== 8'hFF) oe_bad++;
      if (cyc + 1 == kick) start[u] = 1'b1;
      @(posedge clk);
      cyc++;
      #1 start[u] = 1'b0;
    end
    r = rq.pop_front();
    checks++;
    if (done[u] !== 1'b1 || cyc != r.cyc)
      $display("FAIL done_cycle u%0d: got %0d (done=%b) want %0d", u, cyc, done[u], r.cyc);
    else passed++;
    checks++;
    if (oe_bad != 0)
      $display("FAIL busy_oe u%0d: %0d bad cycles want 0", u, oe_bad);
    else passed++;
    checks++;
    if (vq.size() != 0)
      $display("FAIL vec_count u%0d: %0d unseen want 0", u, vq.size());
    else passed++;
    checks++;
    if (b_oe[u] !== 8'h00 || busy[u] !== 1'b0)
      $display("FAIL release u%0d: oe=%h busy=%b want 00 0", u, b_oe[u], busy[u]);
    else passed++;
    checks++;
    if (err_count[u] !== r.err)
      $display("FAIL err_count u%0d: got %h want %h", u, err_count[u], r.err);
    else passed++;
    checks++;
    if (first_fail[u] !== r.ff)
      $display("FAIL first_fail u%0d: got %h want %h", u, first_fail[u], r.ff);
    else passed++;
    checks++;
    if (pass[u] !== r.ps)
      $display("FAIL pass u%0d: got %b want %b", u, pass[u], r.ps);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 3'b111;
    start = 3'b000;
    repeat (2) @(posedge clk);
    #1 rst = 3'b000;
    checks++;
    if ({a_out[0], b_out[0], b_oe[0]} !== 24'h0)
      $display("FAIL rst_vec: got %h want 000000", {a_out[0], b_out[0], b_oe[0]});
    else passed++;
    checks++;
    if ({busy, done, pass} !== 9'h0)
      $display("FAIL rst_flags: got %b want 0", {busy, done, pass});
    else passed++;
    checks++;
    if ({err_count[0], first_fail[0]} !== 24'h0)
      $display("FAIL rst_err: got %h want 000000", {err_count[0], first_fail[0]});
    else passed++;
  endtask

  task automatic test_ideal_sweep();
    rq.push_back('{65, 8'h00, 16'h0000, 1'b1});
    run_sweep(0, 15, 4, 0);
  endtask

  task automatic test_bit0_short();
    force0 = 1'b1;
    rq.push_back('{65, 8'h00, 16'h0000, 1'b1});
    run_sweep(0, 15, 4, 0);
    force0 = 1'b0;
  endtask

  task automatic test_saturate();
    rq.push_back('{512 * 4 + 1, 8'hFF, 16'h0100, 1'b0});
    run_sweep(1, 511, 4, 0);
  endtask

  task automatic test_start_ignored();
    rq.push_back('{65, 8'h00, 16'h0000, 1'b1});
    run_sweep(0, 15, 4, 23);
    checks++;
    if (a_out[0] !== 8'h0F || b_out[0] !== 8'h00)
      $display("FAIL last_vec: got %h%h want 000f", b_out[0], a_out[0]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    checks++;
    if (a_out[0] !== 8'h07 || b_oe[0] !== 8'hFF)
      $display("FAIL mid_vec: got a=%h oe=%h want 07 ff", a_out[0], b_oe[0]);
    else passed++;
    rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    checks++;
    if ({a_out[0], b_out[0], b_oe[0], err_count[0], first_fail[0]} !== 48'h0)
      $display("FAIL mid_rst_regs: got %h want 0",
               {a_out[0], b_out[0], b_oe[0], err_count[0], first_fail[0]});
    else passed++;
    checks++;
    if ({busy[0], done[0], pass[0]} !== 3'b000)
      $display("FAIL mid_rst_flags: got %b want 000", {busy[0], done[0], pass[0]});
    else passed++;
    rq.push_back('{65, 8'h00, 16'h0000, 1'b1});
    run_sweep(0, 15, 4, 0);
  endtask

  task automatic test_settle_delay();
    dsel = 1'b0;
    rq.push_back('{512 * 3 + 1, 8'h00, 16'h0000, 1'b1});
    run_sweep(2, 511, 3, 0);
    rst[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst[2] = 1'b0;
    dsel = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rq.push_back('{512 * 3 + 1, 8'h01, 16'h0100, 1'b0});
    run_sweep(2, 511, 3, 0);
  endtask

  initial begin
    force0 = 1'b0;
    dsel   = 1'b0;
    test_reset();
    test_ideal_sweep();
    test_bit0_short();
    test_saturate();
    test_start_ignored();
    test_reset_mid();
    test_settle_delay();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
